// File: rtl/tdm_demux_1x8.sv
// Receive-side TDM demultiplexer: tracks the slot index of a framed word stream
// and presents each complete 8-slot frame in parallel with a one-cycle strobe.
module tdm_demux_1x8 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sync,
  output logic [8*WIDTH-1:0]   out,
  output logic                 frame_valid,
  output logic [2:0]           slot,
  output logic                 locked,
  output logic                 sync_err
);

  localparam int unsigned NSLOT  = 8;
  localparam int unsigned NSHAD  = NSLOT - 1;
  localparam int unsigned SLOTW  = 3;
  localparam logic [SLOTW-1:0] LAST_SLOT = SLOTW'(NSLOT - 1);

  typedef enum logic [0:0] {HUNT = 1'b0, RUN = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [WIDTH-1:0]        shadow [NSHAD];
  logic [SLOTW-1:0]        slot_nxt;
  logic                    wr_en;
  logic [SLOTW-1:0]        wr_idx;
  logic                    load_out;
  logic                    fv_nxt;
  logic                    err_nxt;
  logic [8*WIDTH-1:0]      frame_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      slot        <= '0;
      out         <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      for (int k = 0; k < int'(NSHAD); k++) shadow[k] <= '0;
    end else begin
      state       <= state_nxt;
      slot        <= slot_nxt;
      frame_valid <= fv_nxt;
      sync_err    <= err_nxt;
      if (load_out) out <= frame_c;
      for (int k = 0; k < int'(NSHAD); k++) begin
        if (wr_en && (wr_idx == SLOTW'(k))) shadow[k] <= in_data;
      end
    end
  end

  // Next-state: enter RUN on a sync beat, fall back to HUNT when a frame start is missing
  always_comb begin
    state_nxt = state;
    unique case (state)
      HUNT: if (in_valid && in_sync) state_nxt = RUN;
      RUN:  if (in_valid && !in_sync && (slot == '0)) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  // Slot tracking, shadow writes and flag generation
  always_comb begin
    slot_nxt = slot;
    wr_en    = 1'b0;
    wr_idx   = slot;
    load_out = 1'b0;
    fv_nxt   = 1'b0;
    err_nxt  = 1'b0;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (in_sync) begin
            wr_en    = 1'b1;
            wr_idx   = '0;
            slot_nxt = SLOTW'(1);
          end
        end
        RUN: begin
          if (in_sync) begin
            // Early sync restarts the frame from this beat
            wr_en    = 1'b1;
            wr_idx   = '0;
            slot_nxt = SLOTW'(1);
            err_nxt  = (slot != '0);
          end else if (slot == '0) begin
            err_nxt  = 1'b1;
            slot_nxt = '0;
          end else if (slot == LAST_SLOT) begin
            load_out = 1'b1;
            fv_nxt   = 1'b1;
            slot_nxt = '0;
          end else begin
            wr_en    = 1'b1;
            slot_nxt = slot + SLOTW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Slot 7 is taken straight from the input so it never needs a shadow register
  always_comb begin
    frame_c = '0;
    for (int k = 0; k < int'(NSHAD); k++) frame_c[k*WIDTH +: WIDTH] = shadow[k];
    frame_c[NSHAD*WIDTH +: WIDTH] = in_data;
  end

  assign locked = (state == RUN);

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Directed bench for tdm_demux_1x8 with WIDTH=4 and hand-computed expected frames.
module tb_tdm_demux_1x8;

  localparam int unsigned WIDTH = 4;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic [WIDTH-1:0]    in_data;
  logic                in_sync;
  logic [8*WIDTH-1:0]  out;
  logic                frame_valid;
  logic [2:0]          slot;
  logic                locked;
  logic                sync_err;

  int n_checks = 0;
  int n_pass   = 0;

  tdm_demux_1x8 #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_sync     (in_sync),
    .out         (out),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled at the falling edge
  task automatic beat(input logic s, input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_sync  = s;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_sync  = 1'b0;
    in_data  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_flags(input string tag, input logic fv, input logic err,
                             input logic [2:0] s, input logic lk);
    check({tag, "_fv"},   32'(frame_valid), 32'(fv));
    check({tag, "_err"},  32'(sync_err),    32'(err));
    check({tag, "_slot"}, 32'(slot),        32'(s));
    check({tag, "_lock"}, 32'(locked),      32'(lk));
  endtask

  logic [3:0]  vec [8];
  logic [31:0] exp_out;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sync = 1'b0; in_data = '0;
    @(negedge clk);
    idle(2);
    check("rst_out", out, 32'h0);
    check_flags("rst", 1'b0, 1'b0, 3'd0, 1'b0);
    rst = 1'b0;

    // Clean frame 1..8
    for (int k = 0; k < 8; k++) begin
      beat(k == 0, 4'(k + 1));
      if (k == 6) check_flags("clean_s7", 1'b0, 1'b0, 3'd7, 1'b1);
    end
    check("clean_out", out, 32'h87654321);
    check_flags("clean_done", 1'b1, 1'b0, 3'd0, 1'b1);
    idle(1);
    check("clean_fv_drop", 32'(frame_valid), 32'h0);

    // Sync lost at slot 0
    beat(1'b0, 4'h5);
    check_flags("lost", 1'b0, 1'b1, 3'd0, 1'b0);
    check("lost_out", out, 32'h87654321);
    idle(1);
    check("lost_err_drop", 32'(sync_err), 32'h0);

    // Hunt ignores non-sync beats
    for (int k = 0; k < 3; k++) beat(1'b0, 4'h3);
    check_flags("hunt", 1'b0, 1'b0, 3'd0, 1'b0);
    check("hunt_out", out, 32'h87654321);

    // Gapped frame A,B,C,D,E,F,0,1
    vec = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
    for (int k = 0; k < 8; k++) begin
      beat(k == 0, vec[k]);
      if (k < 7) begin
        idle(2);
        if (k == 3) begin
          check("gap_out_hold", out, 32'h87654321);
          check_flags("gap_mid", 1'b0, 1'b0, 3'd4, 1'b1);
        end
      end
    end
    check("gap_out", out, 32'h10FEDCBA);
    check("gap_fv", 32'(frame_valid), 32'h1);
    idle(1);
    check("gap_fv_drop", 32'(frame_valid), 32'h0);

    // Early sync after 5 beats
    for (int k = 0; k < 5; k++) beat(k == 0, 4'(k + 1));
    beat(1'b1, 4'h9);
    check_flags("early", 1'b0, 1'b1, 3'd1, 1'b1);
    check("early_out", out, 32'h10FEDCBA);
    idle(1);
    check("early_err_drop", 32'(sync_err), 32'h0);
    for (int k = 1; k < 8; k++) beat(1'b0, 4'(k));
    check("early_frame", out, 32'h76543219);
    check_flags("early_done", 1'b1, 1'b0, 3'd0, 1'b1);

    // Reset mid-frame
    for (int k = 0; k < 4; k++) beat(k == 0, 4'hC);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out", out, 32'h0);
    check_flags("midrst", 1'b0, 1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    beat(1'b0, 4'h7);
    check("midrst_hunt_lock", 32'(locked), 32'h0);
    vec = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
    for (int k = 0; k < 8; k++) beat(k == 0, vec[k]);
    check("midrst_frame", out, 32'h89ABCDEF);
    check("midrst_fv", 32'(frame_valid), 32'h1);

    // Three back-to-back frames, no gaps
    idle(1);
    for (int i = 1; i <= 24; i++) begin
      int f, k;
      f = (i - 1) / 8;
      k = (i - 1) % 8;
      in_valid = 1'b1;
      in_sync  = (k == 0);
      in_data  = 4'((f * 3 + k + 1) & 15);
      @(negedge clk);
      if (k == 7) begin
        exp_out = '0;
        for (int j = 0; j < 8; j++) exp_out[j*4 +: 4] = 4'((f * 3 + j + 1) & 15);
        check($sformatf("stream_out%0d", f), out, exp_out);
      end
      check($sformatf("stream_fv_c%0d", i), 32'(frame_valid), 32'(k == 7));
      check($sformatf("stream_err_c%0d", i), 32'(sync_err), 32'h0);
    end
    in_valid = 1'b0; in_sync = 1'b0;
    idle(1);
    check("stream_tail_fv", 32'(frame_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
